sram_like_responder: RTL
========================

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 Parameter DEPTH, default 2, maximum number of accepted-but-unanswered requests (1..4).
REQ-002 Parameter LATENCY, default 1, minimum cycles from acceptance to data_ok (1..7).
REQ-003 Parameter AW, default 10, word-address width; memory holds 2^AW 32-bit words.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 sram_req  in  1  initiator request valid.
REQ-007 sram_wr  in  1  1 = write, 0 = read.
REQ-008 sram_size  in  2  0 byte, 1 half, 2 word; informational only.
REQ-009 sram_addr  in  32  byte address; word index = addr[AW+1:2].
REQ-010 sram_wstrb  in  4  byte enables for writes.
REQ-011 sram_wdata  in  32  write data.
REQ-012 sram_addr_ok  out  1  request accepted this cycle.
REQ-013 sram_data_ok  out  1  one response returned this cycle.
REQ-014 sram_rdata  out  32  read data, meaningful only while sram_data_ok is 1.
REQ-015 addr_stall  in  1  bench back-pressure: forces sram_addr_ok low.
REQ-016 data_stall  in  1  bench back-pressure: forces sram_data_ok low.
REQ-017 outstanding  out  3  current count of queued requests.

Function
REQ-018 Acceptance SHALL occur when sram_req && sram_addr_ok at a rising edge; sram_addr_ok = sram_req && !addr_stall && (outstanding < DEPTH), combinational.
REQ-019 A full queue SHALL deassert sram_addr_ok even if the head is popped the same cycle (no bypass).
REQ-020 On an accepted write, memory bytes with sram_wstrb[i]=1 SHALL update at that edge; sram_wstrb=0 writes nothing but still queues a response.
REQ-021 On an accepted read, the addressed word SHALL be captured into the queue entry at that edge, reflecting all previously accepted writes.
REQ-022 Each queue entry SHALL hold wr flag, captured read data, and an age counter starting at 0, incrementing each cycle, saturating at LATENCY.
REQ-023 sram_data_ok SHALL be 1 when the queue is non-empty, head age >= LATENCY, and data_stall=0; combinational from registers and data_stall.
REQ-024 A data_ok edge SHALL pop the head; exactly one response per accepted request, strictly in acceptance order.
REQ-025 sram_rdata SHALL equal the head's captured word for reads and 32'h0 for writes; 32'h0 when sram_data_ok=0.
REQ-026 Minimum latency: request accepted at edge t SHALL produce sram_data_ok no earlier than the cycle after edge t+LATENCY-1 (LATENCY=1: data_ok in the cycle immediately following acceptance).
REQ-027 Simultaneous accept and pop (not full) SHALL leave outstanding unchanged and preserve order.
REQ-028 Addresses above memory range SHALL wrap modulo 2^AW words; addr[1:0] ignored.
REQ-029 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 While reset=1: sram_addr_ok=0, sram_data_ok=0, sram_rdata=0, outstanding=0, pointers and ages cleared, asynchronously.
REQ-031 Reset mid-operation SHALL discard all queued requests; no data_ok for them after release.
REQ-032 Memory contents SHALL NOT be reset.

Verification
REQ-033 Write addr 0x10 data 0xDEADBEEF wstrb 0xF, then read 0x10, LATENCY=1 -> two data_ok pulses on consecutive cycles, second rdata 0xDEADBEEF.
REQ-034 Partial write 0x11223344 to 0x20, then wstrb 0x2 data 0x0000AA00, read 0x20 -> rdata 0x1122AA44.
REQ-035 DEPTH=2, data_stall=1, three back-to-back reads -> addr_ok for first two, third held, outstanding=2; release stall -> all three answered in order.
REQ-036 LATENCY=3, read accepted at edge t -> data_ok first high after edge t+2, never earlier.
REQ-037 Reset asserted with outstanding=2 -> outputs zero immediately; after release, no data_ok until a new request; memory write from before reset still readable.
REQ-038 Read addr 0x1000 with AW=10 -> returns word at addr 0x0000.

Source files
------------

// File: rtl/sram_like_responder.sv
// SRAM-style slave model: accepts requests into an in-order response queue and answers each
// after a minimum latency, with bench-controlled back-pressure on both handshakes.
module sram_like_responder #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned AW      = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_req,
  input  logic        sram_wr,
  input  logic [1:0]  sram_size,
  input  logic [31:0] sram_addr,
  input  logic [3:0]  sram_wstrb,
  input  logic [31:0] sram_wdata,
  output logic        sram_addr_ok,
  output logic        sram_data_ok,
  output logic [31:0] sram_rdata,
  input  logic        addr_stall,
  input  logic        data_stall,
  output logic [2:0]  outstanding
);

  localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  DepthC = 3'(DEPTH);
  localparam logic [2:0]  LatC   = 3'(LATENCY);

  logic [31:0]   mem [0:(1 << AW) - 1];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;
  logic          q_wr_q   [DEPTH];
  logic [31:0]   q_data_q [DEPTH];
  logic [2:0]    q_age_q  [DEPTH];

  logic [AW-1:0] word_idx;
  logic          push, pop;
  logic          unused_bits;

  assign word_idx    = sram_addr[AW+1:2];
  assign unused_bits = ^{sram_size, sram_addr[1:0], sram_addr[31:AW+2]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Full queue refuses even when the head pops this cycle; reset masks both handshakes.
  assign sram_addr_ok = !reset && sram_req && !addr_stall && (count_q < DepthC);
  assign sram_data_ok = !reset && (count_q != 3'd0) && (q_age_q[rd_ptr_q] >= LatC) &&
                        !data_stall;
  assign sram_rdata   = (sram_data_ok && !q_wr_q[rd_ptr_q]) ? q_data_q[rd_ptr_q] : 32'h0;
  assign outstanding  = count_q;

  assign push = sram_addr_ok;
  assign pop  = sram_data_ok;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_wr_q[i]   <= 1'b0;
        q_data_q[i] <= '0;
        q_age_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_age_q[i] < LatC) q_age_q[i] <= q_age_q[i] + 3'd1;
      end
      if (push) begin
        // Age counts the acceptance cycle, so LATENCY=1 answers in the very next cycle.
        q_wr_q[wr_ptr_q]   <= sram_wr;
        q_data_q[wr_ptr_q] <= sram_wr ? 32'h0 : mem[word_idx];
        q_age_q[wr_ptr_q]  <= 3'd1;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (push && sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wstrb[b]) mem[word_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

endmodule
